sseg_scan_mux: RTL and testbench

//   Time-multiplexed driver for a 4-digit common-anode seven-segment display.

---
 rtl/sseg_scan_mux_if.sv | 27 ++
 rtl/sseg_scan_mux.sv | 125 ++++++++++++
 tb/tb_sseg_scan_mux.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sseg_scan_mux_if.sv
// sseg_scan_mux_if: digit/mask inputs and display-pin outputs of the seven-segment scan driver.
`default_nettype none

interface sseg_scan_mux_if;
  logic [3:0] i_seg3;
  logic [3:0] i_seg2;
  logic [3:0] i_seg1;
  logic [3:0] i_seg0;
  logic [3:0] i_dp;
  logic [3:0] i_en;
  logic [3:0] o_an;
  logic [6:0] o_seg;
  logic       o_dp;
  logic       o_frame_tick;

  modport master (
    output i_seg3, i_seg2, i_seg1, i_seg0, i_dp, i_en,
    input  o_an, o_seg, o_dp, o_frame_tick
  );

  modport slave (
    input  i_seg3, i_seg2, i_seg1, i_seg0, i_dp, i_en,
    output o_an, o_seg, o_dp, o_frame_tick
  );
endinterface

`default_nettype wire

// File: rtl/sseg_scan_mux.sv
// sseg_scan_mux: 4-digit common-anode seven-segment scan driver with per-frame input shadowing.
// Rev 1.0 - initial release.
`default_nettype none

module sseg_scan_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic           i_clk,
  input  logic           i_reset,
  sseg_scan_mux_if.slave bus
);

  localparam int                 c_DIV_W    = $clog2(REFRESH_DIV);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(REFRESH_DIV - 1);

  logic [c_DIV_W-1:0] r_div;
  logic [1:0]         r_idx;
  logic [3:0]         r_sh_seg [4];
  logic [3:0]         r_sh_dp;
  logic [3:0]         r_sh_en;
  logic [3:0]         r_an;
  logic [6:0]         r_seg;
  logic               r_dp;
  logic               r_tick;

  logic               w_wrap;
  logic               w_capture;
  logic               w_blank;
  logic [3:0]         w_an;
  logic [6:0]         w_seg;
  logic               w_dp;

  function automatic logic [6:0] f_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h09;
      4'hB:    seg = 7'h79;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  assign w_wrap    = (r_div == c_DIV_LAST);
  assign w_capture = w_wrap && (r_idx == 2'd3);

  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign w_blank = 1'b0;
    end else begin : g_blank
      assign w_blank = (r_div < c_DIV_W'(BLANK_CYC));
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_div <= '0;
      r_idx <= 2'd0;
    end else if (w_wrap) begin
      r_div <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Shadow load only at the last cycle of slot 3 so a frame never mixes old and new digits.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 4; i++) r_sh_seg[i] <= 4'd0;
      r_sh_dp <= 4'd0;
      r_sh_en <= 4'd0;
    end else if (w_capture) begin
      r_sh_seg[3] <= bus.i_seg3;
      r_sh_seg[2] <= bus.i_seg2;
      r_sh_seg[1] <= bus.i_seg1;
      r_sh_seg[0] <= bus.i_seg0;
      r_sh_dp     <= bus.i_dp;
      r_sh_en     <= bus.i_en;
    end
  end

  always_comb begin
    w_an  = 4'b1111;
    w_seg = 7'h7F;
    w_dp  = 1'b1;
    if (!w_blank && r_sh_en[r_idx]) begin
      w_an  = ~(4'b0001 << r_idx);
      w_seg = f_decode(r_sh_seg[r_idx]);
      w_dp  = ~r_sh_dp[r_idx];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_an   <= 4'b1111;
      r_seg  <= 7'h7F;
      r_dp   <= 1'b1;
      r_tick <= 1'b0;
    end else begin
      r_an   <= w_an;
      r_seg  <= w_seg;
      r_dp   <= w_dp;
      r_tick <= w_capture;
    end
  end

  assign bus.o_an         = r_an;
  assign bus.o_seg        = r_seg;
  assign bus.o_dp         = r_dp;
  assign bus.o_frame_tick = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_sseg_scan_mux.sv
// tb_sseg_scan_mux: directed and randomized checks of sseg_scan_mux against a cycle-count reference model.
`default_nettype none

module tb_sseg_scan_mux;

  localparam int REFRESH_DIV = 8;
  localparam int BLANK_CYC   = 2;
  localparam int FRAME       = 4 * REFRESH_DIV;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sseg_scan_mux_if bus ();

  sseg_scan_mux #(
    .REFRESH_DIV(REFRESH_DIV),
    .BLANK_CYC  (BLANK_CYC)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] ref_decode(input logic [3:0] code);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h09, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    return tbl[code];
  endfunction

  // Reference: elapsed cycles since reset determine slot and position; frame snapshot taken at cycle 31 mod 32.
  int         cyc;
  logic [3:0] m_seg [4];
  logic [3:0] m_dp;
  logic [3:0] m_en;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  logic       e_tick;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc    <= 0;
      m_seg  <= '{4'd0, 4'd0, 4'd0, 4'd0};
      m_dp   <= 4'd0;
      m_en   <= 4'd0;
      e_an   <= 4'hF;
      e_seg  <= 7'h7F;
      e_dp   <= 1'b1;
      e_tick <= 1'b0;
    end else begin
      if ((cyc % REFRESH_DIV) < BLANK_CYC || !m_en[(cyc / REFRESH_DIV) % 4]) begin
        e_an  <= 4'hF;
        e_seg <= 7'h7F;
        e_dp  <= 1'b1;
      end else begin
        e_an  <= 4'hF & ~(4'h1 << ((cyc / REFRESH_DIV) % 4));
        e_seg <= ref_decode(m_seg[(cyc / REFRESH_DIV) % 4]);
        e_dp  <= ~m_dp[(cyc / REFRESH_DIV) % 4];
      end
      e_tick <= ((cyc % FRAME) == FRAME - 1);
      if ((cyc % FRAME) == FRAME - 1) begin
        m_seg <= '{bus.i_seg0, bus.i_seg1, bus.i_seg2, bus.i_seg3};
        m_dp  <= bus.i_dp;
        m_en  <= bus.i_en;
      end
      cyc <= cyc + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("model_an",   32'(bus.o_an),         32'(e_an));
    chk("model_seg",  32'(bus.o_seg),        32'(e_seg));
    chk("model_dp",   32'(bus.o_dp),         32'(e_dp));
    chk("model_tick", 32'(bus.o_frame_tick), 32'(e_tick));
  endtask

  task automatic wait_tick();
    bit got;
    got = 1'b0;
    for (int i = 0; i < FRAME + 8 && !got; i++) begin
      step();
      if (bus.o_frame_tick === 1'b1) got = 1'b1;
    end
    chk("tick_timeout", 32'(got), 32'd1);
  endtask

  task automatic expect_slot(input logic [3:0] an, input logic [6:0] seg, input logic dp);
    for (int i = 0; i < REFRESH_DIV; i++) begin
      step();
      chk("slot_an",  32'(bus.o_an),  (i < BLANK_CYC) ? 32'hF  : 32'(an));
      chk("slot_seg", 32'(bus.o_seg), (i < BLANK_CYC) ? 32'h7F : 32'(seg));
      chk("slot_dp",  32'(bus.o_dp),  (i < BLANK_CYC) ? 32'h1  : 32'(dp));
    end
  endtask

  task automatic set_inputs(input logic [3:0] s3, input logic [3:0] s2, input logic [3:0] s1,
                            input logic [3:0] s0, input logic [3:0] dp, input logic [3:0] en);
    bus.i_seg3 = s3;
    bus.i_seg2 = s2;
    bus.i_seg1 = s1;
    bus.i_seg0 = s0;
    bus.i_dp   = dp;
    bus.i_en   = en;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    set_inputs(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);

    // Reset state, no tick while held
    repeat (3) step();
    chk("reset_an",   32'(bus.o_an),         32'hF);
    chk("reset_seg",  32'(bus.o_seg),        32'h7F);
    chk("reset_dp",   32'(bus.o_dp),         32'h1);
    chk("reset_tick", 32'(bus.o_frame_tick), 32'h0);

    // Scan of 1,2,3,4 with dp on digit 3
    set_inputs(4'd1, 4'd2, 4'd3, 4'd4, 4'b1000, 4'b1111);
    rst = 1'b0;
    wait_tick();
    expect_slot(4'b1110, 7'h19, 1'b1);
    expect_slot(4'b1101, 7'h30, 1'b1);
    expect_slot(4'b1011, 7'h24, 1'b1);
    expect_slot(4'b0111, 7'h79, 1'b0);

    // "HI" on the middle digits
    set_inputs(4'd0, 4'hA, 4'hB, 4'd0, 4'b0000, 4'b0110);
    wait_tick();
    expect_slot(4'b1111, 7'h7F, 1'b1);
    expect_slot(4'b1101, 7'h79, 1'b1);
    expect_slot(4'b1011, 7'h09, 1'b1);
    expect_slot(4'b1111, 7'h7F, 1'b1);

    // Mid-frame change must wait for the next capture
    set_inputs(4'd1, 4'd2, 4'd3, 4'd4, 4'b1000, 4'b1111);
    wait_tick();
    expect_slot(4'b1110, 7'h19, 1'b1);
    bus.i_seg0 = 4'd7;
    expect_slot(4'b1101, 7'h30, 1'b1);
    expect_slot(4'b1011, 7'h24, 1'b1);
    expect_slot(4'b0111, 7'h79, 1'b0);
    chk("tear_tick", 32'(bus.o_frame_tick), 32'h1);
    expect_slot(4'b1110, 7'h78, 1'b1);

    // All digits disabled, then a blank code on an enabled digit
    bus.i_en = 4'b0000;
    wait_tick();
    repeat (4) expect_slot(4'b1111, 7'h7F, 1'b1);
    set_inputs(4'd1, 4'd2, 4'd3, 4'hE, 4'b0000, 4'b1111);
    wait_tick();
    expect_slot(4'b1110, 7'h7F, 1'b1);

    // Asynchronous reset in the middle of slot 2
    set_inputs(4'd1, 4'd2, 4'd3, 4'd7, 4'b1000, 4'b1111);
    wait_tick();
    repeat (2 * REFRESH_DIV + 4) step();
    chk("pre_reset_an", 32'(bus.o_an), 32'b1011);
    rst = 1'b1;
    #1;
    chk("async_reset_an",  32'(bus.o_an),  32'hF);
    chk("async_reset_seg", 32'(bus.o_seg), 32'h7F);
    chk("async_reset_dp",  32'(bus.o_dp),  32'h1);
    repeat (2) step();
    rst = 1'b0;
    repeat (4) expect_slot(4'b1111, 7'h7F, 1'b1);
    chk("post_reset_tick", 32'(bus.o_frame_tick), 32'h1);
    expect_slot(4'b1110, 7'h78, 1'b1);

    // Random input churn against the model
    for (int n = 0; n < 8 * FRAME; n++) begin
      if ($urandom_range(3) == 0) begin
        set_inputs(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                   4'($urandom), 4'($urandom));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
